bht_predictor: RTL and testbench

BHT_PREDICTOR -- requirements
Module: bht_predictor

---
 rtl/bht_predictor.sv | 184 ++++++++++++++++++
 tb/tb_bht_predictor.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_predictor.sv
// ---------------------------------------------------------------------------
// bht_predictor
//
// Branch history table of 2-bit saturating counters. The fetch stage asks for
// a direction prediction and gets it one cycle later. The execute stage
// reports resolved conditional branches, which train the table and update two
// saturating statistics counters.
//
// Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
// The predicted direction is the counter MSB.
//
// Optional feature macro: BHT_GSHARE_EN
//   undefined : bimodal indexing, index = pc[IDX_W+1:2]
//   defined   : gshare indexing, index = pc[IDX_W+1:2] ^ GHR, where the GHR is
//               an IDX_W-bit global history register fed by resolved outcomes
//
// Parameters
//   ENTRIES : number of counters, power of two, 4..1024
//   IDX_W   : table index width, $clog2(ENTRIES)
//   PERF_W  : width of the statistics counters
//
// Ports
//   clk           in   single clock, rising edge
//   rst           in   asynchronous active-low reset
//   pred_req      in   lookup request
//   pred_pc       in   fetch address of the branch to predict
//   pred_valid    out  pred_taken is valid this cycle
//   pred_taken    out  predicted direction, 1 = taken
//   upd_valid     in   a conditional branch resolves this cycle
//   upd_pc        in   address of the resolved branch
//   upd_taken     in   actual outcome
//   upd_mispred   in   the earlier prediction for this branch was wrong
//   stat_branches out  resolved branch count, saturating
//   stat_mispreds out  misprediction count, saturating
// ---------------------------------------------------------------------------
module bht_predictor #(
   parameter int ENTRIES = 64,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int PERF_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pred_req,
   input  logic [31:0]       pred_pc,
   output logic              pred_valid,
   output logic              pred_taken,
   input  logic              upd_valid,
   input  logic [31:0]       upd_pc,
   input  logic              upd_taken,
   input  logic              upd_mispred,
   output logic [PERF_W-1:0] stat_branches,
   output logic [PERF_W-1:0] stat_mispreds
);

   localparam logic [1:0] CTR_SNT  = 2'b00;
   localparam logic [1:0] CTR_WNT  = 2'b01;
   localparam logic [1:0] CTR_ST   = 2'b11;

   logic [1:0]        table_q [ENTRIES];
   logic [IDX_W-1:0]  lkp_idx;
   logic [IDX_W-1:0]  upd_idx;
   logic [1:0]        upd_ctr_cur;
   logic [1:0]        upd_ctr_d;

   logic              pred_valid_q, pred_valid_d;
   logic              pred_taken_q, pred_taken_d;
   logic [PERF_W-1:0] stat_br_q, stat_br_d;
   logic [PERF_W-1:0] stat_mp_q, stat_mp_d;

   // Only pc[IDX_W+1:2] selects an entry; the remaining address bits are
   // deliberately ignored.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                             upd_pc[31:IDX_W+2], upd_pc[1:0]};

   // ------------------------------------------------------------------------
   // Index generation
   // ------------------------------------------------------------------------
`ifdef BHT_GSHARE_EN
   logic [IDX_W-1:0] ghr_q, ghr_d;

   // Both lookup and update hash with the history held before this edge, so a
   // resolving branch does not affect its own or a concurrent lookup's index.
   assign lkp_idx = pred_pc[IDX_W+1:2] ^ ghr_q;
   assign upd_idx = upd_pc[IDX_W+1:2] ^ ghr_q;

   always_comb begin
      ghr_d = ghr_q;
      if (upd_valid) begin
         ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end
`else
   assign lkp_idx = pred_pc[IDX_W+1:2];
   assign upd_idx = upd_pc[IDX_W+1:2];
`endif

   // ------------------------------------------------------------------------
   // Counter training
   // ------------------------------------------------------------------------
   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      upd_ctr_cur = table_q[upd_idx];
      upd_ctr_d   = upd_ctr_cur;
      if (upd_taken) begin
         if (upd_ctr_cur != CTR_ST) begin
            upd_ctr_d = upd_ctr_cur + 2'd1;
         end
      end else begin
         if (upd_ctr_cur != CTR_SNT) begin
            upd_ctr_d = upd_ctr_cur - 2'd1;
         end
      end
   end

   // NOTE: the table is built from flops with an asynchronous reset rather
   // than a RAM, because every counter must read weak-NT the moment reset is
   // asserted, without any clock and without an init sweep.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= CTR_WNT;
         end
      end else if (upd_valid) begin
         table_q[upd_idx] <= upd_ctr_d;
      end
   end

   // ------------------------------------------------------------------------
   // Lookup pipeline: the table is read before this edge's write lands, so a
   // same-cycle update to the same entry is not visible to the lookup.
   // ------------------------------------------------------------------------
   always_comb begin
      pred_valid_d = pred_req;
      pred_taken_d = pred_req & table_q[lkp_idx][1];
   end

   // ------------------------------------------------------------------------
   // Saturating statistics
   // ------------------------------------------------------------------------
   always_comb begin
      stat_br_d = stat_br_q;
      stat_mp_d = stat_mp_q;
      if (upd_valid) begin
         if (~&stat_br_q) begin
            stat_br_d = stat_br_q + PERF_W'(1);
         end
         if (upd_mispred && (~&stat_mp_q)) begin
            stat_mp_d = stat_mp_q + PERF_W'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         stat_br_q    <= '0;
         stat_mp_q    <= '0;
      end else begin
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
         stat_br_q    <= stat_br_d;
         stat_mp_q    <= stat_mp_d;
      end
   end

   assign pred_valid    = pred_valid_q;
   assign pred_taken    = pred_taken_q;
   assign stat_branches = stat_br_q;
   assign stat_mispreds = stat_mp_q;

endmodule

// File: tb/tb_bht_predictor.sv
// ---------------------------------------------------------------------------
// tb_bht_predictor
//
// Self-checking bench for bht_predictor. A reference model of the counter
// table, history register and statistics is advanced on every driven edge;
// each lookup pushes its expected direction into a scoreboard queue, popped
// when the DUT presents the response one cycle later. A second instance with
// PERF_W=4 shares all inputs and exercises statistics saturation.
// ---------------------------------------------------------------------------
module tb_bht_predictor;

   localparam int ENTRIES = 64;
   localparam int IDX_W   = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pred_req = 1'b0;
   logic [31:0] pred_pc = '0;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic        upd_mispred = 1'b0;

   logic        pred_valid, pred_taken;
   logic [31:0] stat_branches, stat_mispreds;
   logic        p4_valid, p4_taken;
   logic [3:0]  s4_branches, s4_mispreds;

   int n_cmp = 0;
   int n_err = 0;

   bit               sb_q[$];
   logic             exp_valid;
   logic [1:0]       m_tab [ENTRIES];
   logic [IDX_W-1:0] m_ghr;
   int               m_br;
   int               m_mp;

   always #5 clk = ~clk;

   bht_predictor #(.ENTRIES(ENTRIES), .PERF_W(32)) dut (
      .clk(clk), .rst(rst),
      .pred_req(pred_req), .pred_pc(pred_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_taken(upd_taken), .upd_mispred(upd_mispred),
      .stat_branches(stat_branches), .stat_mispreds(stat_mispreds)
   );

   bht_predictor #(.ENTRIES(ENTRIES), .PERF_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .pred_req(pred_req), .pred_pc(pred_pc),
      .pred_valid(p4_valid), .pred_taken(p4_taken),
      .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_taken(upd_taken), .upd_mispred(upd_mispred),
      .stat_branches(s4_branches), .stat_mispreds(s4_mispreds)
   );

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   function automatic logic [IDX_W-1:0] m_idx(input logic [31:0] pc);
      logic [IDX_W-1:0] b;
      b = pc[IDX_W+1:2];
`ifdef BHT_GSHARE_EN
      return b ^ m_ghr;
`else
      return b;
`endif
   endfunction

   task automatic m_reset();
      for (int i = 0; i < ENTRIES; i++) m_tab[i] = 2'b01;
      m_ghr = '0;
      m_br  = 0;
      m_mp  = 0;
      exp_valid = 1'b0;
      sb_q.delete();
   endtask

   // Drives one cycle of stimulus, advances the model at the edge, and returns
   // 1 ns after the edge with the DUT response settled.
   task automatic step(input logic req, input logic [31:0] pc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic um);
      logic [IDX_W-1:0] li, ui;
      pred_req    = req;
      pred_pc     = pc;
      upd_valid   = uv;
      upd_pc      = upc;
      upd_taken   = ut;
      upd_mispred = um;
      @(posedge clk);
      li = m_idx(pc);
      ui = m_idx(upc);
      if (req) sb_q.push_back(m_tab[li][1]);
      if (uv) begin
         if (ut && m_tab[ui] != 2'b11) m_tab[ui] = m_tab[ui] + 2'd1;
         else if (!ut && m_tab[ui] != 2'b00) m_tab[ui] = m_tab[ui] - 2'd1;
         m_ghr = {m_ghr[IDX_W-2:0], ut};
         m_br++;
         if (um) m_mp++;
      end
      exp_valid = req;
      #1;
      pred_req    = 1'b0;
      upd_valid   = 1'b0;
      upd_mispred = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      pred_req = 1'b0;
      upd_valid = 1'b0;
      m_reset();
      #2;
      rst = 1'b1;
   endtask

   // ------------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------------
   task automatic test_reset();
      m_reset();
      pred_req = 1'b1;
      pred_pc  = 32'h100;
      @(posedge clk);
      #1;
      n_cmp++; if (pred_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", pred_valid); end
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken: got %b want 0", pred_taken); end
      n_cmp++; if (stat_branches !== 32'd0) begin n_err++; $display("FAIL reset_branches: got %0d want 0", stat_branches); end
      n_cmp++; if (stat_mispreds !== 32'd0) begin n_err++; $display("FAIL reset_mispreds: got %0d want 0", stat_mispreds); end
      pred_req = 1'b0;
      rst = 1'b1;
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      n_cmp++; if (pred_valid !== 1'b0) begin n_err++; $display("FAIL first_no_req_valid: got %b want 0", pred_valid); end
   endtask

   task automatic test_basic_lookup();
      bit exp;
      step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
      n_cmp++; if (pred_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", pred_valid); end
      exp = sb_q.pop_front();
      n_cmp++; if (pred_taken !== exp) begin n_err++; $display("FAIL basic_taken: got %b want %b", pred_taken, exp); end
      step(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
      n_cmp++; if (pred_valid !== 1'b0) begin n_err++; $display("FAIL basic_idle_valid: got %b want 0", pred_valid); end
   endtask

   task automatic test_saturation();
      bit exp;
      logic [4:0] ut_seq;
      // taken x2, lookup, taken x3, not-taken, lookup, not-taken, lookup
      step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b0);
      step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
      exp = sb_q.pop_front();
      n_cmp++; if (pred_taken !== exp) begin n_err++; $display("FAIL sat_after_two_taken: got %b want %b", pred_taken, exp); end
      ut_seq = 5'b01110;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 32'h0, 1'b1, 32'h100, ut_seq[i+1], 1'b0);
      end
      step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
      exp = sb_q.pop_front();
      n_cmp++; if (pred_taken !== exp) begin n_err++; $display("FAIL sat_one_nt_from_st: got %b want %b", pred_taken, exp); end
      step(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0);
      step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
      exp = sb_q.pop_front();
      n_cmp++; if (pred_taken !== exp) begin n_err++; $display("FAIL sat_two_nt_from_st: got %b want %b", pred_taken, exp); end
   endtask

   task automatic test_same_cycle();
      bit exp;
      step(1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 1'b0);
      exp = sb_q.pop_front();
      n_cmp++; if (pred_taken !== exp) begin n_err++; $display("FAIL same_cycle_pre_update: got %b want %b", pred_taken, exp); end
      step(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
      exp = sb_q.pop_front();
      n_cmp++; if (pred_taken !== exp) begin n_err++; $display("FAIL same_cycle_next: got %b want %b", pred_taken, exp); end
   endtask

   task automatic test_alias();
      bit exp;
      step(1'b0, 32'h0, 1'b1, 32'h004, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 32'h004, 1'b1, 1'b0);
      step(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0);
      exp = sb_q.pop_front();
      n_cmp++; if (pred_taken !== exp) begin n_err++; $display("FAIL alias_0x104: got %b want %b", pred_taken, exp); end
      // low address bits must not change the entry
      step(1'b1, 32'h107, 1'b0, 32'h0, 1'b0, 1'b0);
      exp = sb_q.pop_front();
      n_cmp++; if (pred_taken !== exp) begin n_err++; $display("FAIL alias_low_bits: got %b want %b", pred_taken, exp); end
   endtask

   task automatic test_stats();
      logic [3:0] e4;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 32'h0, 1'b1, 32'(i * 4), i[0], (i == 2 || i == 5 || i == 9));
      end
      // mispred without valid must be ignored
      step(1'b0, 32'h0, 1'b0, 32'h40, 1'b1, 1'b1);
      n_cmp++; if (stat_branches !== 32'(m_br)) begin n_err++; $display("FAIL stats_branches10: got %0d want %0d", stat_branches, m_br); end
      n_cmp++; if (stat_mispreds !== 32'(m_mp)) begin n_err++; $display("FAIL stats_mispreds3: got %0d want %0d", stat_mispreds, m_mp); end
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 1'b1);
      end
      n_cmp++; if (stat_branches !== 32'(m_br)) begin n_err++; $display("FAIL stats_branches20: got %0d want %0d", stat_branches, m_br); end
      e4 = 4'((m_br > 15) ? 15 : m_br);
      n_cmp++; if (s4_branches !== e4) begin n_err++; $display("FAIL stats_sat_branches: got %0d want %0d", s4_branches, e4); end
      e4 = 4'((m_mp > 15) ? 15 : m_mp);
      n_cmp++; if (s4_mispreds !== e4) begin n_err++; $display("FAIL stats_sat_mispreds: got %0d want %0d", s4_mispreds, e4); end
   endtask

   task automatic test_back_to_back();
      bit          exp;
      logic [3:0]  e4;
      logic [31:0] pc, upc;
      for (int c = 0; c < 400; c++) begin
         pc  = {23'd0, 7'($urandom_range(0, 127)), 2'($urandom_range(0, 3))};
         upc = {23'd0, 7'($urandom_range(0, 127)), 2'($urandom_range(0, 3))};
         step(($urandom_range(0, 9) < 7), pc, ($urandom_range(0, 1) == 1), upc,
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
         n_cmp++; if (pred_valid !== exp_valid) begin n_err++; $display("FAIL b2b_valid cyc %0d: got %b want %b", c, pred_valid, exp_valid); end
         if (exp_valid) begin
            exp = sb_q.pop_front();
            n_cmp++; if (pred_taken !== exp) begin n_err++; $display("FAIL b2b_taken cyc %0d: got %b want %b", c, pred_taken, exp); end
         end
         if (c % 32 == 31) begin
            n_cmp++; if (stat_branches !== 32'(m_br)) begin n_err++; $display("FAIL b2b_branches cyc %0d: got %0d want %0d", c, stat_branches, m_br); end
            n_cmp++; if (stat_mispreds !== 32'(m_mp)) begin n_err++; $display("FAIL b2b_mispreds cyc %0d: got %0d want %0d", c, stat_mispreds, m_mp); end
            e4 = 4'((m_mp > 15) ? 15 : m_mp);
            n_cmp++; if (s4_mispreds !== e4) begin n_err++; $display("FAIL b2b_sat_mispreds cyc %0d: got %0d want %0d", c, s4_mispreds, e4); end
         end
      end
   endtask

   task automatic test_reset_inflight();
      bit exp;
      // strengthen 0x300 to strong-T, then start a lookup and reset mid-flight
      step(1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 1'b0);
      step(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 1'b0);
      n_cmp++; if (pred_valid !== 1'b1) begin n_err++; $display("FAIL inflight_pre_valid: got %b want 1", pred_valid); end
      rst = 1'b0;
      m_reset();
      #1;
      n_cmp++; if (pred_valid !== 1'b0) begin n_err++; $display("FAIL inflight_async_valid: got %b want 0", pred_valid); end
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL inflight_async_taken: got %b want 0", pred_taken); end
      n_cmp++; if (stat_branches !== 32'd0) begin n_err++; $display("FAIL inflight_async_branches: got %0d want 0", stat_branches); end
      n_cmp++; if (stat_mispreds !== 32'd0) begin n_err++; $display("FAIL inflight_async_mispreds: got %0d want 0", stat_mispreds); end
      // a request held during reset must not produce a response
      pred_req = 1'b1;
      pred_pc  = 32'h300;
      @(posedge clk);
      #1;
      n_cmp++; if (pred_valid !== 1'b0) begin n_err++; $display("FAIL req_in_reset_valid: got %b want 0", pred_valid); end
      pred_req = 1'b0;
      rst = 1'b1;
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      n_cmp++; if (pred_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_idle_valid: got %b want 0", pred_valid); end
      // counter must be back at weak-NT: one not-taken gives strong-NT
      step(1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 1'b0);
      step(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
      exp = sb_q.pop_front();
      n_cmp++; if (pred_taken !== exp) begin n_err++; $display("FAIL post_reset_ctr_300: got %b want %b", pred_taken, exp); end
      // and one taken on a fresh entry gives weak-T
      step(1'b0, 32'h0, 1'b1, 32'h3c0, 1'b1, 1'b0);
      step(1'b1, 32'h3c0, 1'b0, 32'h0, 1'b0, 1'b0);
      exp = sb_q.pop_front();
      n_cmp++; if (pred_taken !== exp) begin n_err++; $display("FAIL post_reset_ctr_3c0: got %b want %b", pred_taken, exp); end
   endtask

   initial begin
      test_reset();
      test_basic_lookup();
      test_saturation();
      test_same_cycle();
      test_alias();
      test_stats();
      test_back_to_back();
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
